// File: rtl/mem_bus_if_if.sv
// Classic Wishbone-style bus bundle between the memory-stage master and a slave.
interface mem_bus_if_if;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;

  modport master (
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
    input  bus_dat_i, bus_ack_i
  );

  modport slave (
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_adr_o, bus_dat_o,
    output bus_dat_i, bus_ack_i
  );
endinterface

// File: rtl/mem_bus_if.sv
// Memory-stage data-bus master: one classic bus cycle per aligned load/store,
// stalls the pipeline until the slave acks, returns extended load data and
// flags misaligned accesses without issuing them.
module mem_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        adel_o,
  output logic        ades_o,
  mem_bus_if_if.master bus
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic        cyc_q, we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q;
  logic [7:0]  op_q;
  logic [1:0]  lane_q;

  logic        is_load, is_store, misaligned, issue;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Decode the EX/MEM op into lane selects, store data and alignment.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    sel_c      = 4'b0000;
    wdata_c    = mem_reg2_i;
    unique case (mem_aluop_i)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        sel_c   = 4'b1000 >> mem_addr_i[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load    = 1'b1;
        sel_c      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        misaligned = mem_addr_i[0];
      end
      OP_LW: begin
        is_load    = 1'b1;
        sel_c      = 4'b1111;
        misaligned = |mem_addr_i[1:0];
      end
      OP_SB: begin
        is_store = 1'b1;
        sel_c    = 4'b1000 >> mem_addr_i[1:0];
        wdata_c  = {4{mem_reg2_i[7:0]}};
      end
      OP_SH: begin
        is_store   = 1'b1;
        sel_c      = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_c    = {2{mem_reg2_i[15:0]}};
        misaligned = mem_addr_i[0];
      end
      OP_SW: begin
        is_store   = 1'b1;
        sel_c      = 4'b1111;
        misaligned = |mem_addr_i[1:0];
      end
      default: ;
    endcase
  end

  assign adel_o     = is_load & misaligned;
  assign ades_o     = is_store & misaligned;
  assign issue      = (is_load | is_store) & ~misaligned & ~flush_i;
  assign stallreq_o = ((state == S_IDLE) & issue) | (state == S_BUSY);

  // Pick the big-endian lane of the read word and extend it per the latched op.
  always_comb begin
    unique case (lane_q)
      2'd0:    rd_byte = bus.bus_dat_i[31:24];
      2'd1:    rd_byte = bus.bus_dat_i[23:16];
      2'd2:    rd_byte = bus.bus_dat_i[15:8];
      default: rd_byte = bus.bus_dat_i[7:0];
    endcase
    rd_half = lane_q[1] ? bus.bus_dat_i[15:0] : bus.bus_dat_i[31:16];
    unique case (op_q)
      OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  rd_ext = {24'h0, rd_byte};
      OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  rd_ext = {16'h0, rd_half};
      default: rd_ext = bus.bus_dat_i;
    endcase
  end

  // Access sequencer: issue in IDLE, wait for ack in BUSY, hold result in DONE.
  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the datapath registers are reset as well, so every bus and
      // result output reads 0 straight out of reset.
      state       <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'h0;
      dat_q       <= 32'h0;
      op_q        <= 8'h0;
      lane_q      <= 2'd0;
      load_data_o <= 32'h0;
      done_o      <= 1'b0;
    end else if (flush_i) begin
      // A flush aborts the access; a same-cycle ack is dropped with it.
      state  <= S_IDLE;
      cyc_q  <= 1'b0;
      done_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (issue) begin
          state  <= S_BUSY;
          cyc_q  <= 1'b1;
          we_q   <= is_store;
          sel_q  <= sel_c;
          adr_q  <= {mem_addr_i[31:2], 2'b00};
          dat_q  <= wdata_c;
          op_q   <= mem_aluop_i;
          lane_q <= mem_addr_i[1:0];
        end
        S_BUSY: if (bus.bus_ack_i) begin
          state  <= S_DONE;
          cyc_q  <= 1'b0;
          done_o <= 1'b1;
          if (!we_q) load_data_o <= rd_ext;
        end
        S_DONE: if (!stall_i[4]) begin
          // The instruction moves on here, so it is never reissued.
          state  <= S_IDLE;
          done_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_cyc_o = cyc_q;
  assign bus.bus_stb_o = cyc_q;
  assign bus.bus_we_o  = we_q;
  assign bus.bus_sel_o = sel_q;
  assign bus.bus_adr_o = adr_q;
  assign bus.bus_dat_o = dat_q;

  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

endmodule
